// File: rtl/axi_lite_pkg.sv
// Shared definitions for the TIMER AXI4-Lite responder: response codes,
// register offsets, CTRL/STATUS bit positions and the byte-strobe merge helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [11:0] TMR_CTRL     = 12'h000;
  localparam logic [11:0] TMR_LOAD     = 12'h004;
  localparam logic [11:0] TMR_COUNT    = 12'h008;
  localparam logic [11:0] TMR_STATUS   = 12'h00C;
  localparam logic [11:0] TMR_PRESCALE = 12'h010;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IE          = 2;
  localparam int STATUS_IRQ       = 0;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_LOAD,
    SEL_COUNT,
    SEL_STATUS,
    SEL_PRESCALE,
    SEL_NONE
  } reg_sel_e;

  // Byte-lane merge: lanes with a strobe take the new data, others keep the old value
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_timer_slave_core.sv
// timer_core: prescaler, down-counter, auto-reload and IRQ-set event generation.
// Optional prescaler is built only when TIMER_PRESCALER_EN is defined; otherwise
// the counter ticks every cycle while enabled.
module timer_core #(
  parameter int CNT_W = 32
`ifdef TIMER_PRESCALER_EN
  , parameter int PRE_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_q,
  input  logic             load_wr,
  input  logic [CNT_W-1:0] load_wdata,
`ifdef TIMER_PRESCALER_EN
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic [CNT_W-1:0] count,
  output logic             irq_set,
  output logic             en_clr
);

  logic tick;

`ifdef TIMER_PRESCALER_EN
  logic [PRE_W-1:0] pre_cnt;

  // >= rather than == so that lowering PRESCALE below the running count cannot stall the tick
  assign tick = en & (pre_cnt >= prescale);

  // Prescaler divides by PRESCALE+1; LOAD writes and EN rising restart the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (load_wr | restart) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign tick = en;
`endif

  // Underflow is a tick that finds the counter already at zero
  assign irq_set = tick & (count == '0);
  assign en_clr  = irq_set & ~auto_reload;

  // Down-counter; a LOAD write overrides a coincident tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load_wr) begin
      count <= load_wdata;
    end else if (tick) begin
      if (count == '0) begin
        if (auto_reload) count <= load_q;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_timer_slave.sv
// AXI4-Lite responder for the TIMER window: bus handshakes, address decode and
// register writes; counting is delegated to timer_core.
// Optional PRESCALE register at 0x10 is enabled by defining TIMER_PRESCALER_EN.
module axi_lite_timer_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              irq
);

  if (CNT_W < 1 || CNT_W > 32 || PRE_W < 1 || PRE_W > 32 || ADDR_W < 5) begin : g_bad_params
    $error("axi_lite_timer_slave: parameter out of range");
  end

  logic              alive;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        ctrl_q;
  logic [CNT_W-1:0]  load_q;
  logic [CNT_W-1:0]  count;
  logic              irq_q;
  logic              irq_set, en_clr;
  logic              commit, ctrl_wr, load_wr, status_clr;
  logic [31:0]       wr_merged;
  reg_sel_e          wsel, rsel;
`ifdef TIMER_PRESCALER_EN
  logic [PRE_W-1:0]  pre_q;
  logic              pre_wr, en_rise;
`endif

  function automatic reg_sel_e decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = {a[ADDR_W-1:2], 2'b00};
    if (w == ADDR_W'(TMR_CTRL))     return SEL_CTRL;
    if (w == ADDR_W'(TMR_LOAD))     return SEL_LOAD;
    if (w == ADDR_W'(TMR_COUNT))    return SEL_COUNT;
    if (w == ADDR_W'(TMR_STATUS))   return SEL_STATUS;
`ifdef TIMER_PRESCALER_EN
    if (w == ADDR_W'(TMR_PRESCALE)) return SEL_PRESCALE;
`endif
    return SEL_NONE;
  endfunction

  function automatic logic [31:0] read_reg(input reg_sel_e sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      SEL_CTRL:     v[2:0]        = ctrl_q;
      SEL_LOAD:     v[CNT_W-1:0]  = load_q;
      SEL_COUNT:    v[CNT_W-1:0]  = count;
      SEL_STATUS:   v[STATUS_IRQ] = irq_q;
`ifdef TIMER_PRESCALER_EN
      SEL_PRESCALE: v[PRE_W-1:0]  = pre_q;
`endif
      default:      v             = '0;
    endcase
    return v;
  endfunction

  assign s_awready = alive & ~aw_held & ~s_bvalid;
  assign s_wready  = alive & ~w_held & ~s_bvalid;
  assign s_arready = alive & ~s_rvalid;
  assign irq       = irq_q & ctrl_q[CTRL_IE];

  assign commit     = aw_held & w_held;
  assign wsel       = decode(aw_addr_q);
  assign rsel       = decode(s_araddr);
  assign wr_merged  = apply_wstrb(read_reg(wsel), wdata_q, wstrb_q);
  assign ctrl_wr    = commit & (wsel == SEL_CTRL);
  // An all-zero strobe must not reload COUNT or restart the prescaler
  assign load_wr    = commit & (wsel == SEL_LOAD) & (|wstrb_q);
  assign status_clr = commit & (wsel == SEL_STATUS) & wstrb_q[0] & wdata_q[STATUS_IRQ];
`ifdef TIMER_PRESCALER_EN
  assign pre_wr     = commit & (wsel == SEL_PRESCALE);
  assign en_rise    = ctrl_wr & wr_merged[CTRL_EN] & ~ctrl_q[CTRL_EN];
`endif

  // Ready gating, write holding flags and the B channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive    <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else begin
      alive <= 1'b1;
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= (wsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (s_awvalid & s_awready) aw_held <= 1'b1;
        if (s_wvalid & s_wready)   w_held  <= 1'b1;
        if (s_bvalid & s_bready)   s_bvalid <= 1'b0;
      end
    end
  end

  // Address/data holding registers; only meaningful while the matching held flag is set
  always_ff @(posedge clk) begin
    if (s_awvalid & s_awready) aw_addr_q <= s_awaddr;
    if (s_wvalid & s_wready) begin
      wdata_q <= s_wdata;
      wstrb_q <= s_wstrb;
    end
  end

  // R channel: data captured at the AR handshake, held until the master accepts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (s_arvalid & s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= read_reg(rsel);
      s_rresp  <= (rsel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (s_rvalid & s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  // Software-visible registers; hardware IRQ set beats a coincident W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      load_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr)     ctrl_q <= wr_merged[2:0];
      else if (en_clr) ctrl_q[CTRL_EN] <= 1'b0;
      if (load_wr)     load_q <= wr_merged[CNT_W-1:0];
      if (irq_set)     irq_q <= 1'b1;
      else if (status_clr) irq_q <= 1'b0;
    end
  end

`ifdef TIMER_PRESCALER_EN
  // PRESCALE register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre_q <= '0;
    else if (pre_wr) pre_q <= wr_merged[PRE_W-1:0];
  end
`endif

  timer_core #(
    .CNT_W(CNT_W)
`ifdef TIMER_PRESCALER_EN
    , .PRE_W(PRE_W)
`endif
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .en          (ctrl_q[CTRL_EN]),
    .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
    .load_q      (load_q),
    .load_wr     (load_wr),
    .load_wdata  (wr_merged[CNT_W-1:0]),
`ifdef TIMER_PRESCALER_EN
    .restart     (en_rise),
    .prescale    (pre_q),
`endif
    .count       (count),
    .irq_set     (irq_set),
    .en_clr      (en_clr)
  );

endmodule

// File: tb/tb_axi_lite_timer_slave.sv
// Self-checking bench for axi_lite_timer_slave (default build, no prescaler).
module tb_axi_lite_timer_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [11:0] s_araddr;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid, s_rready;
  logic        irq;

  axi_lite_timer_slave dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NVEC = 28;
  vec_t tbl [NVEC];
  vec_t exp_q [$];
  vec_t e;

  int checks = 0;
  int failures = 0;

  logic [1:0]  resp;
  logic [31:0] got, expc, d0;

  function automatic vec_t mk(input logic wr, input logic [11:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // which: 0 aw&w ready, 1 awready, 2 wready, 3 arready, 4 bvalid, 5 rvalid
  task automatic wait_for(input int which, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      case (which)
        0: ok = s_awready && s_wready;
        1: ok = s_awready;
        2: ok = s_wready;
        3: ok = s_arready;
        4: ok = s_bvalid;
        default: ok = s_rvalid;
      endcase
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: signal stayed low for 50 cycles, required high", name);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] r);
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    wait_for(0, "aw_w_ready");
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_for(4, "bvalid");
    r = s_bresp;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    wait_for(3, "arready");
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    wait_for(5, "rvalid");
    d = s_rdata;
    r = s_rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Register-level vectors, timer stopped throughout
    tbl[0]  = mk(0, 12'h000, 0, 0, 32'h0, OKAY);
    tbl[1]  = mk(0, 12'h004, 0, 0, 32'h0, OKAY);
    tbl[2]  = mk(0, 12'h008, 0, 0, 32'h0, OKAY);
    tbl[3]  = mk(0, 12'h00C, 0, 0, 32'h0, OKAY);
    tbl[4]  = mk(0, 12'h010, 0, 0, 32'h0, SLVERR);
    tbl[5]  = mk(1, 12'h010, 32'hFFFF, 4'hF, 0, SLVERR);
    tbl[6]  = mk(1, 12'h004, 32'h1234_5678, 4'hF, 0, OKAY);
    tbl[7]  = mk(0, 12'h004, 0, 0, 32'h1234_5678, OKAY);
    tbl[8]  = mk(0, 12'h008, 0, 0, 32'h1234_5678, OKAY);
    tbl[9]  = mk(1, 12'h004, 32'hAABB_CCDD, 4'h2, 0, OKAY);
    tbl[10] = mk(0, 12'h004, 0, 0, 32'h1234_CC78, OKAY);
    tbl[11] = mk(0, 12'h008, 0, 0, 32'h1234_CC78, OKAY);
    tbl[12] = mk(1, 12'h004, 32'h0, 4'h0, 0, OKAY);
    tbl[13] = mk(0, 12'h004, 0, 0, 32'h1234_CC78, OKAY);
    tbl[14] = mk(1, 12'h008, 32'h55, 4'hF, 0, OKAY);
    tbl[15] = mk(0, 12'h008, 0, 0, 32'h1234_CC78, OKAY);
    tbl[16] = mk(1, 12'h020, 32'hFFFF_FFFF, 4'hF, 0, SLVERR);
    tbl[17] = mk(0, 12'h020, 0, 0, 32'h0, SLVERR);
    tbl[18] = mk(0, 12'h004, 0, 0, 32'h1234_CC78, OKAY);
    tbl[19] = mk(1, 12'h007, 32'h0000_00FF, 4'hF, 0, OKAY);
    tbl[20] = mk(0, 12'h005, 0, 0, 32'h0000_00FF, OKAY);
    tbl[21] = mk(1, 12'h000, 32'hFFFF_FFF8, 4'hF, 0, OKAY);
    tbl[22] = mk(0, 12'h000, 0, 0, 32'h0, OKAY);
    tbl[23] = mk(1, 12'h000, 32'h4, 4'hF, 0, OKAY);
    tbl[24] = mk(0, 12'h000, 0, 0, 32'h4, OKAY);
    tbl[25] = mk(1, 12'h00C, 32'h1, 4'hF, 0, OKAY);
    tbl[26] = mk(0, 12'h00C, 0, 0, 32'h0, OKAY);
    tbl[27] = mk(1, 12'h000, 32'h0, 4'hF, 0, OKAY);

    reset = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", s_awready, 0);
    check("rst_wready", s_wready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_rresp", s_rresp, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_irq", irq, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rel0_awready", s_awready, 0);
    check("rel0_arready", s_arready, 0);
    @(negedge clk);
    check("rel1_awready", s_awready, 1);
    check("rel1_wready", s_wready, 1);
    check("rel1_arready", s_arready, 1);

    // Table vectors through the scoreboard
    for (int i = 0; i < NVEC; i++) begin
      exp_q.push_back(tbl[i]);
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, resp);
        got = '0;
      end else begin
        do_read(tbl[i].addr, got, resp);
      end
      e = exp_q.pop_front();
      check($sformatf("vec%0d_resp", i), resp, e.exp_resp);
      if (!e.wr) check($sformatf("vec%0d_data", i), got, e.exp_data);
    end

    // Auto-reload count sequence: reads land every 2 cycles, so COUNT steps by 2 mod 6
    do_write(12'h004, 32'd5, 4'hF, resp);
    check("t1_load_bresp", resp, OKAY);
    do_write(12'h000, 32'h3, 4'hF, resp);
    check("t1_ctrl_bresp", resp, OKAY);
    do_read(12'h008, got, resp);
    check("t1_count_in_range", got <= 32'd5, 1);
    expc = got;
    for (int k = 0; k < 8; k++) begin
      expc = (expc + 32'd4) % 32'd6;
      do_read(12'h008, got, resp);
      check($sformatf("t1_count_seq%0d", k), got, expc);
    end
    do_read(12'h00C, got, resp);
    check("t1_status_irq", got, 32'h1);
    check("t1_irq_masked", irq, 0);
    do_write(12'h000, 32'h0, 4'hF, resp);
    do_write(12'h00C, 32'h1, 4'hF, resp);
    do_read(12'h00C, got, resp);
    check("t1_status_cleared", got, 32'h0);

    // W three cycles ahead of AW
    s_wdata = 32'h1234; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    wait_for(2, "t2_wready");
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t2_wready_low%0d", k), s_wready, 0);
      check($sformatf("t2_bvalid_low%0d", k), s_bvalid, 0);
    end
    @(posedge clk); #1;
    s_awaddr = 12'h004; s_awvalid = 1'b1;
    wait_for(1, "t2_awready");
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    check("t2_bvalid_not_yet", s_bvalid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_bvalid", s_bvalid, 1);
    check("t2_bresp", s_bresp, OKAY);
    @(posedge clk); #1;
    do_read(12'h004, got, resp);
    check("t2_load_readback", got, 32'h1234);
    do_read(12'h008, got, resp);
    check("t2_count_copied", got, 32'h1234);

    // R held with rready low while the counter runs
    do_write(12'h000, 32'h3, 4'hF, resp);
    s_araddr = 12'h008; s_arvalid = 1'b1; s_rready = 1'b0;
    wait_for(3, "t3_arready");
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    d0 = s_rdata;
    check("t3_rvalid", s_rvalid, 1);
    check("t3_rdata_range", (d0 <= 32'h1234) && (d0 >= 32'h1200), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t3_rvalid_hold%0d", k), s_rvalid, 1);
      check($sformatf("t3_rdata_hold%0d", k), s_rdata, d0);
      check($sformatf("t3_arready_low%0d", k), s_arready, 0);
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_rvalid_done", s_rvalid, 0);
    check("t3_arready_back", s_arready, 1);
    @(posedge clk); #1;
    do_write(12'h000, 32'h0, 4'hF, resp);

    // W1C landing on the underflow edge: set wins
    do_write(12'h00C, 32'h1, 4'hF, resp);
    do_write(12'h004, 32'd2, 4'hF, resp);
    s_awaddr = 12'h000; s_wdata = 32'h5; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    wait_for(0, "t5_ctrl_ready");
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(posedge clk); #1;
    s_awaddr = 12'h00C; s_wdata = 32'h1;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_for(0, "t5_status_ready");
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("t5_irq_before", irq, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_irq_set_wins", irq, 1);
    check("t5_bvalid", s_bvalid, 1);
    check("t5_bresp", s_bresp, OKAY);
    @(posedge clk); #1;
    do_read(12'h00C, got, resp);
    check("t5_status", got, 32'h1);
    do_read(12'h000, got, resp);
    check("t5_ctrl_en_cleared", got, 32'h4);
    do_read(12'h008, got, resp);
    check("t5_count_zero", got, 32'h0);
    do_write(12'h00C, 32'h1, 4'hF, resp);
    @(negedge clk);
    check("t5_irq_cleared", irq, 0);
    @(posedge clk); #1;
    do_read(12'h00C, got, resp);
    check("t5_status_cleared", got, 32'h0);

    // Asynchronous reset with B and R outstanding
    do_write(12'h004, 32'h0, 4'hF, resp);
    do_write(12'h000, 32'h5, 4'hF, resp);
    @(negedge clk);
    check("t6_irq_pre", irq, 1);
    @(posedge clk); #1;
    s_bready = 1'b0;
    s_awaddr = 12'h004; s_wdata = 32'h77; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_for(0, "t6_aw_w_ready");
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 12'h00C; s_arvalid = 1'b1; s_rready = 1'b0;
    wait_for(3, "t6_arready");
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    check("t6_bvalid_pre", s_bvalid, 1);
    check("t6_rvalid_pre", s_rvalid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_bvalid_async", s_bvalid, 0);
    check("t6_rvalid_async", s_rvalid, 0);
    check("t6_irq_async", irq, 0);
    check("t6_awready_async", s_awready, 0);
    check("t6_arready_async", s_arready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    check("t6_awready_rel0", s_awready, 0);
    check("t6_wready_rel0", s_wready, 0);
    check("t6_arready_rel0", s_arready, 0);
    @(negedge clk);
    check("t6_awready_rel1", s_awready, 1);
    check("t6_wready_rel1", s_wready, 1);
    check("t6_arready_rel1", s_arready, 1);
    @(posedge clk); #1;
    do_read(12'h000, got, resp);
    check("t6_ctrl_reset", got, 32'h0);
    do_read(12'h004, got, resp);
    check("t6_load_reset", got, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
